// File: rtl/fetch_pc_unit.sv
// Fetch/next-PC stage: FETCH over req/ack, one EXEC cycle per instruction, min 2 cycles/instr.
// Backpressure: stall holds EXEC; a missing imem_ack for ACK_TIMEOUT cycles halts the stage with fetch_err.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic [2:0]  BranchOp,
  input  logic        Jump,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        stall,
  output logic        fetch_err
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture, advance, timeout;
  logic          taken;
  logic [31:0]   pc4, br_off, next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pc        <= RESET_PC;
      instr     <= '0;
      fetch_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) instr     <= imem_rdata;
      if (advance) pc        <= next_pc;
      if (timeout) fetch_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    advance = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (cnt_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        if (!stall) begin
          advance = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (BranchOp)
      3'b001:  taken = alu_zero;
      3'b010:  taken = !alu_neg;
      3'b011:  taken = !alu_neg && !alu_zero;
      3'b100:  taken = alu_neg || alu_zero;
      3'b101:  taken = !alu_zero;
      default: taken = 1'b0;
    endcase
  end

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (Jump)       next_pc = {pc4[31:28], instr[25:0], 2'b00};
    else if (taken) next_pc = pc4 + br_off;
  end

  assign imem_addr   = pc;
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed program walk through fetch_pc_unit; a negedge monitor checks each EXEC against a scoreboard.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [2:0]  BranchOp;
  logic        Jump;
  logic        alu_zero;
  logic        alu_neg;
  logic        stall;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .BranchOp(BranchOp), .Jump(Jump), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .stall(stall), .fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [31:0] epc;
    logic [31:0] einstr;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  exp_t        sb_e;
  int          gap_q[$];
  int          cyc = 0;
  int          last_rise = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Monitor: the first EXEC cycle of each instruction pops one expected (pc, instr).
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        gap_q.push_back(cyc - last_rise);
        last_rise = cyc;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: unexpected instr_valid at pc %h, required none", pc);
        end else begin
          sb_e = sb_q.pop_front();
          check32("sb_pc", pc, sb_e.epc);
          check32("sb_instr", instr, sb_e.einstr);
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic wait_req(input string tag);
    int t = 0;
    while (!imem_req && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL %s_req_timeout: imem_req=%b after %0d cycles, required 1", tag, imem_req, t);
    end
  endtask

  // One instruction: ack after `delay` idle FETCH cycles, drive control inputs for its EXEC.
  task automatic run_instr(input logic [31:0] word, input logic [2:0] bop, input logic jmp,
                           input logic z, input logic n, input int delay,
                           input logic [31:0] nxt, input int stall_cyc);
    logic [31:0] cur;
    wait_req("fetch");
    check32("imem_addr", imem_addr, exp_pc);
    sb_q.push_back(exp_t'{exp_pc, word});
    cur    = exp_pc;
    exp_pc = nxt;
    repeat (delay) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = word;
    BranchOp   = bop;
    Jump       = jmp;
    alu_zero   = z;
    alu_neg    = n;
    stall      = (stall_cyc > 0);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i < stall_cyc; i++) begin
      check1("stall_valid", instr_valid, 1'b1);
      check32("stall_pc", pc, cur);
      check32("stall_instr", instr, word);
      if (i == stall_cyc - 1) stall = 1'b0;
      @(negedge clk);
    end
  endtask

  // {BranchOp, alu_zero, alu_neg, taken}
  logic [5:0] sweep [15] = '{
    {3'b010, 1'b0, 1'b0, 1'b1}, {3'b010, 1'b0, 1'b1, 1'b0}, {3'b010, 1'b1, 1'b0, 1'b1},
    {3'b011, 1'b0, 1'b0, 1'b1}, {3'b011, 1'b0, 1'b1, 1'b0}, {3'b011, 1'b1, 1'b0, 1'b0},
    {3'b100, 1'b0, 1'b0, 1'b0}, {3'b100, 1'b0, 1'b1, 1'b1}, {3'b100, 1'b1, 1'b0, 1'b1},
    {3'b101, 1'b0, 1'b0, 1'b1}, {3'b101, 1'b0, 1'b1, 1'b1}, {3'b101, 1'b1, 1'b0, 1'b0},
    {3'b110, 1'b0, 1'b0, 1'b0}, {3'b110, 1'b1, 1'b0, 1'b0}, {3'b111, 1'b0, 1'b0, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] s;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; BranchOp = 3'b000;
    Jump = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; stall = 1'b0;
    exp_pc = 32'h0;
    repeat (2) @(negedge clk);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_err", fetch_err, 1'b0);
    check32("rst_pc", pc, 32'h0);
    check32("rst_instr", instr, 32'h0);
    rst_n = 1'b1;

    // Sequential R-type stream, ack one cycle after req, then jump back to 0.
    run_instr(32'h012A_4020, 3'b000, 1'b0, 1'b0, 1'b0, 1, 32'h4, 0);
    run_instr(32'h014B_5022, 3'b000, 1'b0, 1'b0, 1'b0, 1, 32'h8, 0);
    run_instr(32'h016C_6024, 3'b000, 1'b0, 1'b0, 1'b0, 1, 32'hC, 0);
    run_instr(32'h0800_0000, 3'b000, 1'b1, 1'b0, 1'b0, 1, 32'h0, 0);

    // Branch sweep at pc=0 with imm=4; each followed by a jump back to 0.
    for (int i = 0; i < 15; i++) begin
      s = sweep[i];
      run_instr({6'h01, 10'h0, 16'h0004}, s[5:3], 1'b0, s[2], s[1], i % 3,
                s[0] ? 32'h14 : 32'h4, 0);
      run_instr(32'h0800_0000, 3'b000, 1'b1, 1'b0, 1'b0, 0, 32'h0, 0);
    end

    if (gap_q.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL gap_count: got %0d EXEC entries, required at least 4", gap_q.size());
    end else begin
      for (int i = 1; i < 4; i++) check32("gap_r_type", 32'(gap_q[i]), 32'd3);
    end

    // Backward branch from 0 wraps to the top of the address space and back.
    run_instr(32'h1000_FFFE, 3'b001, 1'b0, 1'b1, 1'b0, 1, 32'hFFFF_FFFC, 0);
    run_instr(32'h0000_0020, 3'b000, 1'b0, 1'b0, 1'b0, 2, 32'h0, 0);

    // beq at 0x40, taken then not taken.
    run_instr(32'h0800_0010, 3'b000, 1'b1, 1'b0, 1'b0, 1, 32'h40, 0);
    run_instr(32'h1000_FFFE, 3'b001, 1'b0, 1'b1, 1'b0, 1, 32'h3C, 0);
    run_instr(32'h0800_0010, 3'b000, 1'b1, 1'b0, 1'b0, 1, 32'h40, 0);
    run_instr(32'h1000_FFFE, 3'b001, 1'b0, 1'b0, 1'b0, 1, 32'h44, 0);

    // Walk into the 0x1 region, then a jump that outranks a taken beq.
    run_instr(32'h0BFF_FFFF, 3'b000, 1'b1, 1'b0, 1'b0, 1, 32'h0FFF_FFFC, 0);
    run_instr(32'h0000_0020, 3'b000, 1'b0, 1'b0, 1'b0, 1, 32'h1000_0000, 0);
    run_instr(32'h1000_0003, 3'b001, 1'b0, 1'b1, 1'b0, 1, 32'h1000_0010, 0);
    run_instr(32'h0800_0100, 3'b001, 1'b1, 1'b1, 1'b0, 1, 32'h1000_0400, 0);

    // Five stalled EXEC cycles, then reset in the middle of the next fetch.
    run_instr(32'h0232_8020, 3'b000, 1'b0, 1'b0, 1'b0, 1, 32'h1000_0404, 5);
    wait_req("pre_reset");
    check32("pre_reset_addr", imem_addr, 32'h1000_0404);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_req", imem_req, 1'b0);
    check1("mid_rst_valid", instr_valid, 1'b0);
    check32("mid_rst_pc", pc, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    exp_pc = 32'h0;

    // Ack on the last allowed FETCH cycle still completes the fetch.
    run_instr(32'h0273_9020, 3'b000, 1'b0, 1'b0, 1'b0, 15, 32'h4, 0);
    check1("late_ack_err", fetch_err, 1'b0);

    // No ack at all: halt with a sticky error, ack afterwards is ignored.
    wait_req("timeout");
    check32("timeout_addr", imem_addr, 32'h4);
    repeat (15) @(negedge clk);
    check1("pre_tmo_req", imem_req, 1'b1);
    check1("pre_tmo_err", fetch_err, 1'b0);
    @(negedge clk);
    check1("tmo_err", fetch_err, 1'b1);
    check1("tmo_req", imem_req, 1'b0);
    check1("tmo_valid", instr_valid, 1'b0);
    check32("tmo_pc", pc, 32'h4);
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    check1("halt_req", imem_req, 1'b0);
    check1("halt_err", fetch_err, 1'b1);
    check32("halt_instr", instr, 32'h0273_9020);

    check32("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
